// File: rtl/controlador_preparo_if.sv
// Handshake bundle between the coffee-machine sequencer and its environment
// (user request inputs, payment-machine link and actuator enables).
interface controlador_preparo_if;
  logic       iniciar;
  logic       cancelar;
  logic [1:0] produto;
  logic [1:0] status_pag;
  logic [1:0] produto_sel;
  logic       timer;
  logic       limpa_pag;
  logic       aquecedor;
  logic       moedor;
  logic       valvula;
  logic       devolver;
  logic       pronto;
  logic       ocupado;
  logic [2:0] estado_atual;

  modport master (
    output iniciar,
    output cancelar,
    output produto,
    output status_pag,
    input  produto_sel,
    input  timer,
    input  limpa_pag,
    input  aquecedor,
    input  moedor,
    input  valvula,
    input  devolver,
    input  pronto,
    input  ocupado,
    input  estado_atual
  );

  modport slave (
    input  iniciar,
    input  cancelar,
    input  produto,
    input  status_pag,
    output produto_sel,
    output timer,
    output limpa_pag,
    output aquecedor,
    output moedor,
    output valvula,
    output devolver,
    output pronto,
    output ocupado,
    output estado_atual
  );
endinterface

// File: rtl/controlador_preparo.sv
// Top-level coffee-machine sequencer: payment handshake, then timed heater,
// grinder and dispense phases, or a refund when payment does not complete.
module controlador_preparo #(
  parameter int unsigned T_PAGAMENTO = 20,
  parameter int unsigned T_AQUECER   = 8,
  parameter int unsigned T_MOER      = 4,
  parameter int unsigned T_CURTO     = 6,
  parameter int unsigned T_LONGO     = 12,
  parameter int unsigned T_PRONTO    = 3,
  parameter int unsigned CW          = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  controlador_preparo_if.slave bus
);

  typedef enum logic [2:0] {
    StOcioso      = 3'b000,
    StPagando     = 3'b001,
    StAquecendo   = 3'b010,
    StMoendo      = 3'b011,
    StDispensando = 3'b100,
    StFinalizado  = 3'b101,
    StEstorno     = 3'b110
  } estado_e;

  // Terminal counts: a timed state of length T exits when the counter is T-1.
  localparam logic [CW-1:0] FimPagamento = CW'(T_PAGAMENTO - 1);
  localparam logic [CW-1:0] FimAquecer   = CW'(T_AQUECER - 1);
  localparam logic [CW-1:0] FimMoer      = CW'(T_MOER - 1);
  localparam logic [CW-1:0] FimCurto     = CW'(T_CURTO - 1);
  localparam logic [CW-1:0] FimLongo     = CW'(T_LONGO - 1);
  localparam logic [CW-1:0] FimPronto    = CW'(T_PRONTO - 1);

  estado_e       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic          timer_q, timer_d;
  logic          limpa_q, limpa_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= StOcioso;
      cnt_q    <= '0;
      sel_q    <= 2'b00;
      timer_q  <= 1'b0;
      limpa_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      timer_q  <= timer_d;
      limpa_q  <= limpa_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    sel_d    = sel_q;
    case (estado_q)
      StOcioso: begin
        if (bus.iniciar) begin
          estado_d = StPagando;
          sel_d    = bus.produto;
        end
      end
      StPagando: begin
        // Payment confirmation beats a simultaneous cancel or timeout.
        if (bus.status_pag == 2'b11) begin
          estado_d = StAquecendo;
        end else if (bus.status_pag == 2'b10 || bus.cancelar || timer_q) begin
          estado_d = StEstorno;
        end
      end
      StAquecendo: begin
        if (cnt_q == FimAquecer) begin
          estado_d = sel_q[1] ? StMoendo : StDispensando;
        end
      end
      StMoendo: begin
        if (cnt_q == FimMoer) begin
          estado_d = StDispensando;
        end
      end
      StDispensando: begin
        if (cnt_q == (sel_q[0] ? FimLongo : FimCurto)) begin
          estado_d = StFinalizado;
        end
      end
      StFinalizado: begin
        if (cnt_q == FimPronto) begin
          estado_d = StOcioso;
        end
      end
      StEstorno: estado_d = StOcioso;
      default:   estado_d = StOcioso;
    endcase

    cnt_d   = (estado_d != estado_q) ? '0 : cnt_q + CW'(1);
    // Sticky for the rest of the payment window once the limit is reached.
    timer_d = (estado_d == StPagando) && (timer_q || cnt_d == FimPagamento);
    limpa_d = (estado_q == StFinalizado || estado_q == StEstorno) && (estado_d == StOcioso);
  end

  assign bus.produto_sel  = sel_q;
  assign bus.timer        = timer_q;
  assign bus.limpa_pag    = limpa_q;
  assign bus.aquecedor    = (estado_q == StAquecendo);
  assign bus.moedor       = (estado_q == StMoendo);
  assign bus.valvula      = (estado_q == StDispensando);
  assign bus.pronto       = (estado_q == StFinalizado);
  assign bus.devolver     = (estado_q == StEstorno);
  assign bus.ocupado      = (estado_q != StOcioso);
  assign bus.estado_atual = estado_q;

endmodule

// File: tb/tb_controlador_preparo.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a phase-queue model of the sequencer.
module tb_controlador_preparo;

  localparam int T_PAG = 20;
  localparam int T_AQ  = 8;
  localparam int T_MO  = 4;
  localparam int T_CU  = 6;
  localparam int T_LO  = 12;
  localparam int T_PR  = 3;

  localparam int SO = 0;
  localparam int SP = 1;
  localparam int SA = 2;
  localparam int SM = 3;
  localparam int SD = 4;
  localparam int SF = 5;
  localparam int SE = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  controlador_preparo_if bus ();

  controlador_preparo dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: current phase, cycles spent paying, queue of upcoming timed phases.
  int       cur;
  int       k;
  int       q[$];
  logic [1:0] sel;
  bit       limpa;

  int cyc_n;
  int cnt_aq, cnt_mo, cnt_va, cnt_pr, cnt_dv, cnt_lp, cnt_tm;
  int first_aq, first_va, first_pr, first_dv, first_lp, first_tm;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit ini, input bit can, input logic [1:0] prod,
                        input logic [1:0] st);
    bus.iniciar    = ini;
    bus.cancelar   = can;
    bus.produto    = prod;
    bus.status_pag = st;
  endtask

  task automatic model_reset();
    cur   = SO;
    k     = 0;
    q.delete();
    sel   = 2'b00;
    limpa = 1'b0;
  endtask

  task automatic clear_stats();
    cyc_n  = 0;
    cnt_aq = 0; cnt_mo = 0; cnt_va = 0; cnt_pr = 0; cnt_dv = 0; cnt_lp = 0; cnt_tm = 0;
    first_aq = -1; first_va = -1; first_pr = -1; first_dv = -1; first_lp = -1; first_tm = -1;
  endtask

  task automatic model_adv();
    int nxt;
    if (q.size() > 0) begin
      nxt = q.pop_front();
    end else begin
      case (cur)
        SO: nxt = bus.iniciar ? SP : SO;
        SP: begin
          if (bus.status_pag == 2'b11) begin
            repeat (T_AQ) q.push_back(SA);
            if (sel[1]) repeat (T_MO) q.push_back(SM);
            repeat (sel[0] ? T_LO : T_CU) q.push_back(SD);
            repeat (T_PR) q.push_back(SF);
            nxt = q.pop_front();
          end else if (bus.status_pag == 2'b10 || bus.cancelar || k >= T_PAG - 1) begin
            nxt = SE;
          end else begin
            nxt = SP;
          end
        end
        default: nxt = SO;
      endcase
    end
    limpa = (cur == SF || cur == SE) && nxt == SO;
    if (cur == SO && nxt == SP) sel = bus.produto;
    k   = (cur == SP && nxt == SP) ? k + 1 : 0;
    cur = nxt;
  endtask

  task automatic check_cycle();
    logic [7:0] hot;
    chk("estado",      8'(bus.estado_atual), 8'(cur));
    chk("aquecedor",   8'(bus.aquecedor),    8'(cur == SA));
    chk("moedor",      8'(bus.moedor),       8'(cur == SM));
    chk("valvula",     8'(bus.valvula),      8'(cur == SD));
    chk("pronto",      8'(bus.pronto),       8'(cur == SF));
    chk("devolver",    8'(bus.devolver),     8'(cur == SE));
    chk("ocupado",     8'(bus.ocupado),      8'(cur != SO));
    chk("timer",       8'(bus.timer),        8'(cur == SP && k >= T_PAG - 1));
    chk("limpa_pag",   8'(bus.limpa_pag),    8'(limpa));
    chk("produto_sel", 8'(bus.produto_sel),  8'(sel));
    hot = 8'(bus.aquecedor) + 8'(bus.moedor) + 8'(bus.valvula) + 8'(bus.pronto)
        + 8'(bus.devolver);
    chk("mutex", 8'(hot <= 8'd1), 8'd1);
    chk("no_111", 8'(bus.estado_atual == 3'b111), 8'd0);
    if (bus.aquecedor === 1'b1) begin cnt_aq++; if (first_aq < 0) first_aq = cyc_n; end
    if (bus.moedor === 1'b1)    cnt_mo++;
    if (bus.valvula === 1'b1)   begin cnt_va++; if (first_va < 0) first_va = cyc_n; end
    if (bus.pronto === 1'b1)    begin cnt_pr++; if (first_pr < 0) first_pr = cyc_n; end
    if (bus.devolver === 1'b1)  begin cnt_dv++; if (first_dv < 0) first_dv = cyc_n; end
    if (bus.limpa_pag === 1'b1) begin cnt_lp++; if (first_lp < 0) first_lp = cyc_n; end
    if (bus.timer === 1'b1)     begin cnt_tm++; if (first_tm < 0) first_tm = cyc_n; end
  endtask

  task automatic cyc();
    model_adv();
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    check_cycle();
  endtask

  initial begin
    int r;
    logic [1:0] st;
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 2'b00, 2'b00);
    model_reset();
    clear_stats();
    repeat (2) @(negedge clk);
    check_cycle();
    rst_n = 1'b1;
    repeat (2) cyc();
    chk("no_limpa_after_reset", 8'(cnt_lp), 8'd0);

    // Long product with grinding, paid in cycle 5.
    clear_stats();
    set_in(1'b1, 1'b0, 2'b11, 2'b00); cyc();
    set_in(1'b0, 1'b0, 2'b11, 2'b01); repeat (4) cyc();
    set_in(1'b0, 1'b0, 2'b11, 2'b11); cyc();
    set_in(1'b0, 1'b0, 2'b11, 2'b01); repeat (30) cyc();
    chk("t1_first_aq", 8'(first_aq), 8'd6);
    chk("t1_cnt_aq",   8'(cnt_aq),   8'd8);
    chk("t1_cnt_mo",   8'(cnt_mo),   8'd4);
    chk("t1_first_va", 8'(first_va), 8'd18);
    chk("t1_cnt_va",   8'(cnt_va),   8'd12);
    chk("t1_first_pr", 8'(first_pr), 8'd30);
    chk("t1_cnt_pr",   8'(cnt_pr),   8'd3);
    chk("t1_first_lp", 8'(first_lp), 8'd33);
    chk("t1_cnt_lp",   8'(cnt_lp),   8'd1);

    // Short product, no grinding, paid in cycle 3.
    clear_stats();
    set_in(1'b1, 1'b0, 2'b00, 2'b00); cyc();
    set_in(1'b0, 1'b0, 2'b00, 2'b01); repeat (2) cyc();
    set_in(1'b0, 1'b0, 2'b00, 2'b11); cyc();
    set_in(1'b0, 1'b0, 2'b00, 2'b00); repeat (20) cyc();
    chk("t2_first_aq", 8'(first_aq), 8'd4);
    chk("t2_cnt_mo",   8'(cnt_mo),   8'd0);
    chk("t2_first_va", 8'(first_va), 8'd12);
    chk("t2_cnt_va",   8'(cnt_va),   8'd6);
    chk("t2_first_pr", 8'(first_pr), 8'd18);

    // Payment timeout.
    clear_stats();
    set_in(1'b1, 1'b0, 2'b10, 2'b00); cyc();
    set_in(1'b0, 1'b0, 2'b10, 2'b01); repeat (25) cyc();
    chk("t3_first_tm", 8'(first_tm), 8'd20);
    chk("t3_cnt_tm",   8'(cnt_tm),   8'd1);
    chk("t3_first_dv", 8'(first_dv), 8'd21);
    chk("t3_first_lp", 8'(first_lp), 8'd22);
    chk("t3_cnt_aq",   8'(cnt_aq),   8'd0);

    // Incorrect payment in cycle 4.
    clear_stats();
    set_in(1'b1, 1'b0, 2'b01, 2'b00); cyc();
    set_in(1'b0, 1'b0, 2'b01, 2'b01); repeat (3) cyc();
    set_in(1'b0, 1'b0, 2'b01, 2'b10); cyc();
    set_in(1'b0, 1'b0, 2'b01, 2'b00); repeat (4) cyc();
    chk("t4_first_dv", 8'(first_dv), 8'd5);
    chk("t4_cnt_dv",   8'(cnt_dv),   8'd1);
    chk("t4_first_lp", 8'(first_lp), 8'd6);

    // Cancel together with paid: paid wins.
    clear_stats();
    set_in(1'b1, 1'b0, 2'b01, 2'b00); cyc();
    set_in(1'b0, 1'b1, 2'b01, 2'b11); cyc();
    set_in(1'b0, 1'b0, 2'b01, 2'b00); repeat (30) cyc();
    chk("t4b_first_aq", 8'(first_aq), 8'd2);
    chk("t4b_cnt_dv",   8'(cnt_dv),   8'd0);
    chk("t4b_cnt_va",   8'(cnt_va),   8'd12);

    // INICIAR ignored mid-dispense, then asynchronous reset.
    clear_stats();
    set_in(1'b1, 1'b0, 2'b01, 2'b00); cyc();
    set_in(1'b0, 1'b0, 2'b01, 2'b11); cyc();
    set_in(1'b0, 1'b0, 2'b01, 2'b00); repeat (8) cyc();
    set_in(1'b1, 1'b0, 2'b10, 2'b00); repeat (3) cyc();
    chk("t5_valvula_on", 8'(bus.valvula),     8'd1);
    chk("t5_sel_hold",   8'(bus.produto_sel), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valvula_off", 8'(bus.valvula),      8'd0);
    chk("t5_estado_rst",  8'(bus.estado_atual), 8'd0);
    chk("t5_devolver",    8'(bus.devolver),     8'd0);
    chk("t5_limpa",       8'(bus.limpa_pag),    8'd0);
    chk("t5_sel_rst",     8'(bus.produto_sel),  8'd0);
    model_reset();
    set_in(1'b0, 1'b0, 2'b00, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("t5_no_limpa", 8'(cnt_lp), 8'd0);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      r  = int'($urandom_range(0, 31));
      st = (r == 0) ? 2'b11 : (r == 1) ? 2'b10 : (r < 20) ? 2'b01 : 2'b00;
      set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
             2'($urandom_range(0, 3)), st);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/controlador_preparo.md
Name: controlador_preparo

Overview:
- Top-level sequencer for the coffee machine.
- Accepts a start request and product code, then drives the payment machine: latched product, payment timeout flag and a clear pulse.
- Reads back the 2-bit payment status. Once paid, it sequences the heater, grinder and dispense valve for timed intervals.
- If payment fails, times out or is cancelled, it issues a refund pulse instead of preparing.

Parameters:
- T_PAGAMENTO, 20, cycles allowed in payment before TIMER asserts
- T_AQUECER, 8, heater-on cycles
- T_MOER, 4, grinder-on cycles
- T_CURTO, 6, dispense cycles, short drink (PRODUTO[0]=0)
- T_LONGO, 12, dispense cycles, long drink (PRODUTO[0]=1)
- T_PRONTO, 3, cycles PRONTO is held
- CW, 8, cycle-counter width; every T_* must be ≥1 and ≤2^CW-1

Ports:
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- INICIAR  in  1  start request, sampled in OCIOSO only
- CANCELAR  in  1  cancel request, honoured in PAGANDO only
- PRODUTO  in  2  product code, latched when INICIAR is accepted
- STATUS_PAG  in  2  payment status: 00 idle, 01 receiving, 10 incorrect, 11 paid
- PRODUTO_SEL  out  2  latched product, to payment machine
- TIMER  out  1  payment timeout flag, to payment machine
- LIMPA_PAG  out  1  one-cycle clear pulse, to payment machine
- AQUECEDOR  out  1  heater enable
- MOEDOR  out  1  grinder enable
- VALVULA  out  1  dispense valve enable
- DEVOLVER  out  1  one-cycle refund pulse
- PRONTO  out  1  drink ready
- OCUPADO  out  1  high in every state except OCIOSO
- ESTADO_ATUAL  out  3  state encoding, for debug and display

Behaviour:

Reset (RESET_N=0, asynchronous):
- State = OCIOSO, counter = 0, PRODUTO_SEL = 00.
- All outputs 0.
- Reset mid-operation aborts immediately; no refund is issued.

State encoding:
- OCIOSO 000, PAGANDO 001, AQUECENDO 010, MOENDO 011, DISPENSANDO 100, FINALIZADO 101, ESTORNO 110.
- Encoding 111 is illegal and recovers to OCIOSO on the next edge.

Counter:
- Clears to 0 on every state change and increments each cycle within a state.
- A timed state of length T exits on the edge where counter == T-1, so it lasts exactly T cycles.

Transitions:
- OCIOSO: INICIAR=1 → PAGANDO next cycle; PRODUTO_SEL ← PRODUTO on the same edge.
- PAGANDO:
  - Priority: STATUS_PAG=11 → AQUECENDO; else STATUS_PAG=10 → ESTORNO; else CANCELAR=1 → ESTORNO; else stay.
  - TIMER goes high on the edge where counter reaches T_PAGAMENTO-1 and stays high while in PAGANDO.
  - One cycle after TIMER is high with no status 11/10, the state goes to ESTORNO.
  - Paid in the same cycle as timeout or cancel: paid wins.
- AQUECENDO: T_AQUECER cycles, then MOENDO if PRODUTO_SEL[1]=1, else DISPENSANDO (hot-water/tea products skip grinding).
- MOENDO: T_MOER cycles → DISPENSANDO.
- DISPENSANDO: T_LONGO cycles if PRODUTO_SEL[0]=1, else T_CURTO → FINALIZADO.
- FINALIZADO: T_PRONTO cycles → OCIOSO.
- ESTORNO: 1 cycle → OCIOSO.
- INICIAR and CANCELAR are ignored outside the states listed above.
- STATUS_PAG changes after PAGANDO are ignored.

Outputs:
- Moore: decoded from the state register only, with no input-to-output combinational path.
  - AQUECEDOR = AQUECENDO
  - MOEDOR = MOENDO
  - VALVULA = DISPENSANDO
  - PRONTO = FINALIZADO
  - DEVOLVER = ESTORNO
  - TIMER as defined under PAGANDO
- LIMPA_PAG is high exactly during the first OCIOSO cycle after FINALIZADO or ESTORNO, via a one-bit registered flag; it is not asserted after reset.
- PRODUTO_SEL holds its value until the next accepted INICIAR.
- Mutual exclusion: at most one of AQUECEDOR, MOEDOR, VALVULA, PRONTO, DEVOLVER is high in any cycle.

Test Plan:
1. Reset, then INICIAR at cycle 0 with PRODUTO=11 and STATUS_PAG=11 applied at cycle 5 → required sequence:
   - PAGANDO cycles 1–5
   - AQUECEDOR cycles 6–13
   - MOEDOR 14–17
   - VALVULA 18–29
   - PRONTO 30–32
   - LIMPA_PAG at 33, OCUPADO low from 33
2. PRODUTO=00, paid at cycle 3 → AQUECEDOR 4–11, MOEDOR never high, VALVULA 12–17, PRONTO 18–20.
3. INICIAR with STATUS_PAG held at 01 → TIMER rises after 20 PAGANDO cycles, DEVOLVER pulses the next cycle, LIMPA_PAG the cycle after; heater never enabled.
4. STATUS_PAG=10 at cycle 4 of PAGANDO → ESTORNO next cycle, DEVOLVER exactly 1 cycle. Separately: CANCELAR together with STATUS_PAG=11 → AQUECENDO (paid wins).
5. Apply RESET_N=0 asynchronously mid-DISPENSANDO → VALVULA drops immediately without waiting for an edge, state 000, no DEVOLVER or LIMPA_PAG. INICIAR during DISPENSANDO with PRODUTO changed → ignored, PRODUTO_SEL unchanged.
6. Random INICIAR/CANCELAR/STATUS_PAG for 10k cycles → mutual-exclusion property holds, every timed state lasts its exact T_* length, and state 111 never appears.
